mdu: RTL

Multiply/divide unit for the MIPS32 execute stage. It sits beside the combinational ALU and owns the architectural HI/LO registers. MULT/MULTU/MTHI/MTLO complete in one cycle. DIV/DIVU run as an iterative 32-step restoring divider, and the pipeline stalls on `busy`. HI/LO outputs feed the EX result mux that serves MFHI/MFLO.

---
 rtl/mdu.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mdu.sv
// MIPS32 multiply/divide unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// W-step restoring divider for DIV/DIVU, owning the architectural HI/LO pair.
module mdu #(
    parameter int W           = 32,
    parameter int MDUOP_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [MDUOP_WIDTH-1:0] mdu_op,
    input  logic [W-1:0]           op1,
    input  logic [W-1:0]           op2,
    input  logic                   flush,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           hi,
    output logic [W-1:0]           lo
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [MDUOP_WIDTH-1:0] OP_MULT  = MDUOP_WIDTH'(1);
    localparam logic [MDUOP_WIDTH-1:0] OP_MULTU = MDUOP_WIDTH'(2);
    localparam logic [MDUOP_WIDTH-1:0] OP_DIV   = MDUOP_WIDTH'(3);
    localparam logic [MDUOP_WIDTH-1:0] OP_DIVU  = MDUOP_WIDTH'(4);
    localparam logic [MDUOP_WIDTH-1:0] OP_MTHI  = MDUOP_WIDTH'(5);
    localparam logic [MDUOP_WIDTH-1:0] OP_MTLO  = MDUOP_WIDTH'(6);

    typedef enum logic {IDLE, DIV} state_t;

    state_t        state;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [CW-1:0] count;
    logic          qsign;
    logic          rsign;
    logic          dvz;

    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] prod_u;
    logic [W-1:0]   abs1;
    logic [W-1:0]   abs2;
    logic           is_div;

    logic [W:0]     trial;
    logic           fits;
    logic [W-1:0]   next_rem;
    logic [W-1:0]   next_dvd;

    // Sign-extending to 2W bits makes the low 2W bits of the unsigned product the signed product.
    assign prod_s = {{W{op1[W-1]}}, op1} * {{W{op2[W-1]}}, op2};
    assign prod_u = {{W{1'b0}}, op1} * {{W{1'b0}}, op2};

    assign is_div = (mdu_op == OP_DIV);
    assign abs1   = (is_div && op1[W-1]) ? -op1 : op1;
    assign abs2   = (is_div && op2[W-1]) ? -op2 : op2;

    // dvd shifts dividend bits out at the top while quotient bits enter at the bottom.
    always_comb begin
        trial    = {rem, dvd[W-1]};
        fits     = (trial >= {1'b0, dvs});
        next_rem = fits ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
        next_dvd = {dvd[W-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            count <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            dvz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (mdu_op)
                            OP_MULT: begin
                                {hi, lo} <= prod_s;
                                done     <= 1'b1;
                            end
                            OP_MULTU: begin
                                {hi, lo} <= prod_u;
                                done     <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                rem   <= '0;
                                dvd   <= abs1;
                                dvs   <= abs2;
                                qsign <= is_div && (op1[W-1] ^ op2[W-1]);
                                rsign <= is_div && op1[W-1];
                                dvz   <= (op2 == '0);
                                count <= '0;
                                busy  <= 1'b1;
                                state <= DIV;
                            end
                            OP_MTHI: hi <= op1;
                            OP_MTLO: lo <= op1;
                            default: ;
                        endcase
                    end
                end
                DIV: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rem   <= next_rem;
                        dvd   <= next_dvd;
                        count <= count + CW'(1);
                        // A zero divisor leaves the dividend magnitude in rem, so the
                        // sign fix-up alone restores the raw op1 into HI.
                        if (count == LAST) begin
                            lo    <= dvz ? '1 : (qsign ? -next_dvd : next_dvd);
                            hi    <= rsign ? -next_rem : next_rem;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
